sm4_stream_master: RTL and testbench
====================================

SM4_STREAM_MASTER -- requirements
Module: sm4_stream_master

Interface
REQ-001 SHALL take parameter word_width_p, default 32: stream word width in bits.
REQ-002 SHALL take parameter group_size_p, default 128: SM4 block width in bits, equal to 4*word_width_p.
REQ-003 SHALL have port clk_i  input  1: single clock; all flops on its rising edge.
REQ-004 SHALL have port reset_ni  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_data_i  input  32: plaintext/ciphertext word from upstream.
REQ-006 SHALL have port in_v_i  input  1: in_data_i valid.
REQ-007 SHALL have port in_ready_o  output  1: block accepts an input word.
REQ-008 SHALL have port key_i  input  128: cipher key, sampled at block issue.
REQ-009 SHALL have port decode_i  input  1: 1 = decrypt, 0 = encrypt; sampled with key_i.
REQ-010 SHALL have port cbc_en_i  input  1: 1 = CBC chaining, 0 = ECB; sampled with key_i.
REQ-011 SHALL have port iv_i  input  128: CBC initial vector.
REQ-012 SHALL have port iv_load_i  input  1: load iv_i into chain register.
REQ-013 SHALL have port eng_content_o  output  128: block to engine content_i.
REQ-014 SHALL have port eng_key_o  output  128: key to engine key_i.
REQ-015 SHALL have port eng_decode_o  output  1: to engine encode_or_decode_i.
REQ-016 SHALL have port eng_v_o  output  1: request valid to engine v_i.
REQ-017 SHALL have port eng_ready_i  input  1: from engine ready_o.
REQ-018 SHALL have port eng_crypt_i  input  128: from engine crypt_o.
REQ-019 SHALL have port eng_v_i  input  1: from engine v_o.
REQ-020 SHALL have port eng_yumi_o  output  1: to engine yumi_i.
REQ-021 SHALL have port out_data_o  output  32: result word downstream.
REQ-022 SHALL have port out_v_o  output  1: out_data_o valid.
REQ-023 SHALL have port out_ready_i  input  1: downstream accepts word.

Function
REQ-024 FSM states SHALL be eFill, eIssue, eWait, eDrain; reset state eFill.
REQ-025 Input transfer SHALL occur on in_v_i & in_ready_o; in_ready_o = (state==eFill).
REQ-026 Words SHALL pack big-endian: 1st word -> bits[127:96], 4th -> bits[31:0]; 2-bit word counter, wraps 3->0.
REQ-027 On 4th input transfer, FSM SHALL go eFill->eIssue and latch key_i, decode_i, cbc_en_i into request registers that cycle.
REQ-028 eng_content_o SHALL be in_block ^ chain when cbc_en & ~decode, else in_block; registered, stable through eIssue.
REQ-029 eng_v_o SHALL equal (state==eIssue); request transfers on eng_v_o & eng_ready_i, then eIssue->eWait.
REQ-030 In eWait, eng_yumi_o SHALL equal eng_v_i; on eng_v_i result SHALL be captured and FSM -> eDrain same edge.
REQ-031 Captured result SHALL be eng_crypt_i ^ chain when cbc_en & decode, else eng_crypt_i.
REQ-032 On capture with cbc_en, chain SHALL update: encrypt -> eng_crypt_i; decrypt -> held input block.
REQ-033 eDrain SHALL emit result words in big-endian order; transfer on out_v_o & out_ready_i; out_v_o = (state==eDrain).
REQ-034 out_data_o SHALL hold stable while out_v_o & ~out_ready_i.
REQ-035 After 4th output transfer FSM SHALL return to eFill; exactly one block in flight at any time.
REQ-036 iv_load_i SHALL load chain <= iv_i only in eFill with word counter 0; ignored otherwise, and has priority over nothing else.
REQ-037 in_v_i outside eFill, eng_v_i outside eWait SHALL be ignored; eng_yumi_o SHALL be 0 outside eWait.
REQ-038 Latency: last input word to eng_v_o high = 1 cycle; eng_v_i to first out_v_o = 1 cycle.

Reset
REQ-039 On reset_ni low, asynchronously: state eFill, counters 0, chain 0, result/packing/request registers 0.
REQ-040 Reset outputs: in_ready_o 1 (after release), eng_v_o 0, eng_yumi_o 0, out_v_o 0, out_data_o 0, eng_content_o 0.
REQ-041 Reset mid-block SHALL discard partial input, in-flight request and undrained result; no stale word emitted.

Verification
REQ-042 ECB encrypt: key=plaintext=0123456789abcdeffedcba9876543210 (4 words) -> out words 681edf34,d206965e,86b3e94f,536e4246.
REQ-043 ECB decrypt of 681edf34d206965e86b3e94f536e4246, same key -> 01234567,89abcdef,fedcba98,76543210.
REQ-044 CBC encrypt, iv=0, two identical blocks of REQ-042 -> block 1 = ECB vector; block 2 = E(P ^ C1); CBC decrypt of both restores P twice.
REQ-045 eng_ready_i held low 5 cycles in eIssue -> eng_v_o stays 1, eng_content_o stable; out_ready_i toggling 1/0 -> each word emitted once, in order.
REQ-046 reset_ni pulsed low after 2 input words and again in eWait -> outputs at reset values; next full block yields correct ECB result.
REQ-047 iv_load_i asserted in eWait -> chain unchanged; asserted in eFill with counter 0 -> next CBC block uses iv_i.

Source files
------------

// File: rtl/sm4_stream_master_if.sv
// Stream-side and engine-side signal bundle for sm4_stream_master.
// master = the block itself, slave = upstream/downstream/engine environment.
interface sm4_stream_master_if #(
  parameter int word_width_p = 32
);
  localparam int group_size_p = 4 * word_width_p;

  logic [word_width_p-1:0] in_data_i;
  logic                    in_v_i;
  logic                    in_ready_o;
  logic [group_size_p-1:0] key_i;
  logic                    decode_i;
  logic                    cbc_en_i;
  logic [group_size_p-1:0] iv_i;
  logic                    iv_load_i;
  logic [group_size_p-1:0] eng_content_o;
  logic [group_size_p-1:0] eng_key_o;
  logic                    eng_decode_o;
  logic                    eng_v_o;
  logic                    eng_ready_i;
  logic [group_size_p-1:0] eng_crypt_i;
  logic                    eng_v_i;
  logic                    eng_yumi_o;
  logic [word_width_p-1:0] out_data_o;
  logic                    out_v_o;
  logic                    out_ready_i;

  modport master (
    input  in_data_i, in_v_i, key_i, decode_i, cbc_en_i, iv_i, iv_load_i,
    input  eng_ready_i, eng_crypt_i, eng_v_i, out_ready_i,
    output in_ready_o, eng_content_o, eng_key_o, eng_decode_o, eng_v_o,
    output eng_yumi_o, out_data_o, out_v_o
  );

  modport slave (
    output in_data_i, in_v_i, key_i, decode_i, cbc_en_i, iv_i, iv_load_i,
    output eng_ready_i, eng_crypt_i, eng_v_i, out_ready_i,
    input  in_ready_o, eng_content_o, eng_key_o, eng_decode_o, eng_v_o,
    input  eng_yumi_o, out_data_o, out_v_o
  );
endinterface

// File: rtl/sm4_stream_master.sv
// Packs four stream words into one SM4 block, runs it through an external
// SM4 engine (ECB or CBC, encrypt or decrypt) and streams the result back out.
module sm4_stream_master #(
  parameter int word_width_p = 32,
  parameter int group_size_p = 128
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  sm4_stream_master_if.master bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    eFill  = 2'd0,
    eIssue = 2'd1,
    eWait  = 2'd2,
    eDrain = 2'd3
  } state_e;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [1:0]              r_cnt;
  logic [group_size_p-1:0] r_in_block;
  logic [group_size_p-1:0] r_chain;
  logic [group_size_p-1:0] r_content;
  logic [group_size_p-1:0] r_key;
  logic [group_size_p-1:0] r_result;
  logic                    r_decode;
  logic                    r_cbc;

  logic                    w_in_fire;
  logic                    w_rsp_fire;
  logic                    w_out_fire;
  logic                    w_last;
  logic [group_size_p-1:0] w_block_full;
  logic [word_width_p-1:0] w_out_word;

  // Every channel is valid/ready: a word or request moves on the rising edge
  // where both are high; eng_yumi_o acknowledges the engine's result the same way.
  always_comb begin
    w_state_nxt    = r_state;
    bus.in_ready_o = 1'b0;
    bus.eng_v_o    = 1'b0;
    bus.eng_yumi_o = 1'b0;
    bus.out_v_o    = 1'b0;
    unique case (r_state)
      eFill: begin
        bus.in_ready_o = 1'b1;
        if (bus.in_v_i && r_cnt == 2'd3) w_state_nxt = eIssue;
      end
      eIssue: begin
        bus.eng_v_o = 1'b1;
        if (bus.eng_ready_i) w_state_nxt = eWait;
      end
      eWait: begin
        bus.eng_yumi_o = bus.eng_v_i;
        if (bus.eng_v_i) w_state_nxt = eDrain;
      end
      eDrain: begin
        bus.out_v_o = 1'b1;
        if (bus.out_ready_i && r_cnt == 2'd3) w_state_nxt = eFill;
      end
      default: w_state_nxt = eFill;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_state <= eFill;
    else           r_state <= w_state_nxt;
  end

  assign w_in_fire    = bus.in_v_i & bus.in_ready_o;
  assign w_rsp_fire   = bus.eng_v_i & bus.eng_yumi_o;
  assign w_out_fire   = bus.out_v_o & bus.out_ready_i;
  assign w_last       = (r_cnt == 2'd3);
  // The fourth word is still on the input bus when the request is built.
  assign w_block_full = {r_in_block[group_size_p-1:word_width_p], bus.in_data_i};

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_cnt      <= 2'd0;
      r_in_block <= '0;
      r_chain    <= '0;
      r_content  <= '0;
      r_key      <= '0;
      r_result   <= '0;
      r_decode   <= 1'b0;
      r_cbc      <= 1'b0;
    end else begin
      if (w_in_fire || w_out_fire) r_cnt <= r_cnt + 2'd1;
      if (w_in_fire) begin
        case (r_cnt)
          2'd0:    r_in_block[4*word_width_p-1 -: word_width_p] <= bus.in_data_i;
          2'd1:    r_in_block[3*word_width_p-1 -: word_width_p] <= bus.in_data_i;
          2'd2:    r_in_block[2*word_width_p-1 -: word_width_p] <= bus.in_data_i;
          default: r_in_block[word_width_p-1:0]                 <= bus.in_data_i;
        endcase
      end
      // IV only lands between blocks, before any word of the next one arrives.
      if (r_state == eFill && r_cnt == 2'd0 && bus.iv_load_i) r_chain <= bus.iv_i;
      if (w_in_fire && w_last) begin
        r_key     <= bus.key_i;
        r_decode  <= bus.decode_i;
        r_cbc     <= bus.cbc_en_i;
        r_content <= (bus.cbc_en_i && !bus.decode_i) ? (w_block_full ^ r_chain)
                                                     : w_block_full;
      end
      if (w_rsp_fire) begin
        r_result <= (r_cbc && r_decode) ? (bus.eng_crypt_i ^ r_chain) : bus.eng_crypt_i;
        if (r_cbc) r_chain <= r_decode ? r_in_block : bus.eng_crypt_i;
      end
    end
  end

  always_comb begin
    w_out_word = r_result[word_width_p-1:0];
    case (r_cnt)
      2'd0:    w_out_word = r_result[4*word_width_p-1 -: word_width_p];
      2'd1:    w_out_word = r_result[3*word_width_p-1 -: word_width_p];
      2'd2:    w_out_word = r_result[2*word_width_p-1 -: word_width_p];
      default: w_out_word = r_result[word_width_p-1:0];
    endcase
  end

  assign bus.out_data_o    = w_out_word;
  assign bus.eng_content_o = r_content;
  assign bus.eng_key_o     = r_key;
  assign bus.eng_decode_o  = r_decode;
  assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_sm4_stream_master.sv
// Directed bench for sm4_stream_master with a behavioural SM4 engine stand-in
// that knows the reference vector pair and uses a reversible XOR mix otherwise.
module tb_sm4_stream_master;

  localparam logic [127:0] VEC_K = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] VEC_P = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] VEC_C = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] VEC_M = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] IV1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] IV2   = 128'hfedcba98765432100123456789abcdef;

  logic       clk_i;
  logic       reset_ni;
  logic [1:0] dbg_state;

  sm4_stream_master_if #(.word_width_p(32)) bus ();

  sm4_stream_master #(.word_width_p(32), .group_size_p(128)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int total;
  int bad;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  // engine stand-in controls
  int eng_lat;
  int eng_stall;
  int eng_cnt;
  bit eng_busy;
  logic eng_req_fire;
  logic eng_rsp_fire;
  logic [127:0] eng_res;

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [127:0] toy_engine(input logic [127:0] x, input logic [127:0] k,
                                              input logic dec);
    if (!dec && x == VEC_P && k == VEC_K) return VEC_C;
    if (dec && x == VEC_C && k == VEC_K) return VEC_P;
    return x ^ k ^ VEC_M;
  endfunction

  // ---------------- engine model ----------------
  initial begin
    eng_busy = 0;
    eng_cnt  = 0;
    eng_res  = '0;
    bus.eng_ready_i = 1'b1;
    bus.eng_v_i     = 1'b0;
    bus.eng_crypt_i = '0;
    forever begin
      @(posedge clk_i);
      eng_req_fire = bus.eng_v_o & bus.eng_ready_i;
      eng_rsp_fire = bus.eng_v_i & bus.eng_yumi_o;
      if (eng_req_fire) eng_res = toy_engine(bus.eng_content_o, bus.eng_key_o, bus.eng_decode_o);
      #1;
      if (!reset_ni) begin
        eng_busy        = 0;
        eng_cnt         = 0;
        bus.eng_v_i     = 1'b0;
        bus.eng_crypt_i = '0;
      end else begin
        if (eng_rsp_fire) bus.eng_v_i = 1'b0;
        if (eng_req_fire) begin
          eng_busy = 1;
          eng_cnt  = eng_lat;
        end
        if (eng_busy) begin
          if (eng_cnt <= 1) begin
            bus.eng_v_i     = 1'b1;
            bus.eng_crypt_i = eng_res;
            eng_busy        = 0;
          end else begin
            eng_cnt--;
          end
        end
        if (bus.eng_v_o && eng_stall > 0) eng_stall--;
      end
      bus.eng_ready_i = !eng_busy && !bus.eng_v_i && (eng_stall == 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_words(input logic [127:0] blk, input int first, input int n);
    int g;
    for (int i = first; i < first + n; i++) begin
      bus.in_data_i = blk[127-32*i -: 32];
      bus.in_v_i    = 1'b1;
      g = 0;
      while (!bus.in_ready_o && g < 200) begin
        @(negedge clk_i);
        g++;
      end
      if (g >= 200) begin
        total++; bad++;
        $display("FAIL send_timeout: in_ready_o=%b want 1", bus.in_ready_o);
      end
      @(negedge clk_i);
    end
    bus.in_v_i    = 1'b0;
    bus.in_data_i = '0;
  endtask

  task automatic push_exp(input logic [127:0] blk);
    for (int i = 0; i < 4; i++) exp_q.push_back(blk[127-32*i -: 32]);
  endtask

  task automatic recv_block(input bit toggle, output int hold_err);
    logic [31:0] held;
    bit have_held;
    int cyc;
    got_q.delete();
    hold_err  = 0;
    have_held = 0;
    held      = '0;
    cyc       = 0;
    while (got_q.size() < 4 && cyc < 300) begin
      bus.out_ready_i = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (bus.out_v_o) begin
        if (have_held && bus.out_data_o !== held) hold_err++;
        if (bus.out_ready_i) begin
          got_q.push_back(bus.out_data_o);
          have_held = 0;
        end else begin
          held      = bus.out_data_o;
          have_held = 1;
        end
      end
      @(negedge clk_i);
      cyc++;
    end
    bus.out_ready_i = 1'b0;
    if (cyc >= 300) begin
      total++; bad++;
      $display("FAIL recv_timeout: got %0d words want 4", got_q.size());
    end
  endtask

  task automatic pulse_iv(input logic [127:0] iv);
    bus.iv_i      = iv;
    bus.iv_load_i = 1'b1;
    @(negedge clk_i);
    bus.iv_load_i = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_ni        = 1'b0;
    bus.in_v_i      = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.iv_load_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready_o); end
    total++; if (bus.eng_v_o !== 1'b0) begin bad++; $display("FAIL rst_eng_v: got %b want 0", bus.eng_v_o); end
    total++; if (bus.eng_yumi_o !== 1'b0) begin bad++; $display("FAIL rst_yumi: got %b want 0", bus.eng_yumi_o); end
    total++; if (bus.out_v_o !== 1'b0) begin bad++; $display("FAIL rst_out_v: got %b want 0", bus.out_v_o); end
    total++; if (bus.out_data_o !== 32'h0) begin bad++; $display("FAIL rst_out_data: got %h want 0", bus.out_data_o); end
    total++; if (bus.eng_content_o !== 128'h0) begin bad++; $display("FAIL rst_content: got %h want 0", bus.eng_content_o); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_ecb_encrypt();
    int g;
    int herr;
    logic [31:0] w;
    bus.key_i = VEC_K; bus.decode_i = 1'b0; bus.cbc_en_i = 1'b0;
    send_words(VEC_P, 0, 4);
    total++; if (bus.eng_v_o !== 1'b1) begin bad++; $display("FAIL lat_issue: eng_v_o=%b want 1", bus.eng_v_o); end
    total++; if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL issue_in_ready: got %b want 0", bus.in_ready_o); end
    total++; if (bus.eng_content_o !== VEC_P) begin bad++; $display("FAIL ecb_content: got %h want %h", bus.eng_content_o, VEC_P); end
    total++; if (bus.eng_key_o !== VEC_K) begin bad++; $display("FAIL ecb_key: got %h want %h", bus.eng_key_o, VEC_K); end
    total++; if (bus.eng_decode_o !== 1'b0) begin bad++; $display("FAIL ecb_decode: got %b want 0", bus.eng_decode_o); end
    g = 0;
    while (!bus.eng_v_i && g < 100) begin
      total++; if (bus.eng_yumi_o !== 1'b0) begin bad++; $display("FAIL yumi_idle: got %b want 0", bus.eng_yumi_o); end
      @(negedge clk_i);
      g++;
    end
    @(negedge clk_i);
    total++; if (bus.out_v_o !== 1'b1) begin bad++; $display("FAIL lat_out: out_v_o=%b want 1", bus.out_v_o); end
    push_exp(VEC_C);
    recv_block(1'b0, herr);
    for (int k = 0; k < 4; k++) begin
      w = exp_q.pop_front();
      total++; if (got_q[k] !== w) begin bad++; $display("FAIL ecb_enc_w%0d: got %h want %h", k, got_q[k], w); end
    end
    total++; if (bus.out_v_o !== 1'b0) begin bad++; $display("FAIL post_out_v: got %b want 0", bus.out_v_o); end
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL post_in_ready: got %b want 1", bus.in_ready_o); end
  endtask

  task automatic test_ecb_decrypt();
    int herr;
    logic [31:0] w;
    bus.key_i = VEC_K; bus.decode_i = 1'b1; bus.cbc_en_i = 1'b0;
    send_words(VEC_C, 0, 4);
    total++; if (bus.eng_decode_o !== 1'b1) begin bad++; $display("FAIL dec_flag: got %b want 1", bus.eng_decode_o); end
    total++; if (bus.eng_content_o !== VEC_C) begin bad++; $display("FAIL dec_content: got %h want %h", bus.eng_content_o, VEC_C); end
    push_exp(VEC_P);
    recv_block(1'b0, herr);
    for (int k = 0; k < 4; k++) begin
      w = exp_q.pop_front();
      total++; if (got_q[k] !== w) begin bad++; $display("FAIL ecb_dec_w%0d: got %h want %h", k, got_q[k], w); end
    end
    bus.decode_i = 1'b0;
  endtask

  task automatic test_cbc();
    int herr;
    logic [31:0] w;
    logic [127:0] c2;
    logic [127:0] blk;
    c2 = VEC_P ^ VEC_C ^ VEC_K ^ VEC_M;
    pulse_iv(128'h0);
    bus.key_i = VEC_K; bus.cbc_en_i = 1'b1; bus.decode_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        pulse_iv(128'h0);
        bus.decode_i = 1'b1;
      end
      blk = (b == 2) ? VEC_C : (b == 3) ? c2 : VEC_P;
      send_words(blk, 0, 4);
      case (b)
        0: w = 32'h0;
        default: w = 32'h0;
      endcase
      if (b == 1) begin
        total++; if (bus.eng_content_o !== (VEC_P ^ VEC_C)) begin bad++; $display("FAIL cbc_content1: got %h want %h", bus.eng_content_o, VEC_P ^ VEC_C); end
      end else begin
        total++; if (bus.eng_content_o !== blk) begin bad++; $display("FAIL cbc_content%0d: got %h want %h", b, bus.eng_content_o, blk); end
      end
      push_exp((b == 0) ? VEC_C : (b == 1) ? c2 : VEC_P);
      recv_block(1'b0, herr);
      for (int k = 0; k < 4; k++) begin
        w = exp_q.pop_front();
        total++; if (got_q[k] !== w) begin bad++; $display("FAIL cbc_b%0d_w%0d: got %h want %h", b, k, got_q[k], w); end
      end
    end
    bus.cbc_en_i = 1'b0; bus.decode_i = 1'b0;
  endtask

  task automatic test_stall();
    int herr;
    logic [31:0] w;
    bus.key_i = VEC_K; bus.decode_i = 1'b0; bus.cbc_en_i = 1'b0;
    eng_stall = 6;
    send_words(VEC_P, 0, 4);
    bus.in_v_i    = 1'b1;
    bus.in_data_i = 32'hdeadbeef;
    for (int c = 0; c < 5; c++) begin
      total++; if (bus.eng_v_o !== 1'b1) begin bad++; $display("FAIL stall_v%0d: got %b want 1", c, bus.eng_v_o); end
      total++; if (bus.eng_content_o !== VEC_P) begin bad++; $display("FAIL stall_content%0d: got %h want %h", c, bus.eng_content_o, VEC_P); end
      @(negedge clk_i);
    end
    bus.in_v_i    = 1'b0;
    bus.in_data_i = '0;
    push_exp(VEC_C);
    recv_block(1'b1, herr);
    total++; if (herr !== 0) begin bad++; $display("FAIL out_hold: got %0d changes want 0", herr); end
    for (int k = 0; k < 4; k++) begin
      w = exp_q.pop_front();
      total++; if (got_q[k] !== w) begin bad++; $display("FAIL toggle_w%0d: got %h want %h", k, got_q[k], w); end
    end
    // a following block must still line up on word boundaries
    push_exp(VEC_C);
    send_words(VEC_P, 0, 4);
    recv_block(1'b0, herr);
    for (int k = 0; k < 4; k++) begin
      w = exp_q.pop_front();
      total++; if (got_q[k] !== w) begin bad++; $display("FAIL b2b_w%0d: got %h want %h", k, got_q[k], w); end
    end
  endtask

  task automatic test_reset_mid();
    int herr;
    int g;
    int stale;
    logic [31:0] w;
    bus.key_i = VEC_K; bus.decode_i = 1'b0; bus.cbc_en_i = 1'b0;
    send_words(VEC_C, 0, 2);
    pulse_reset();
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL mid1_in_ready: got %b want 1", bus.in_ready_o); end
    total++; if (bus.eng_content_o !== 128'h0) begin bad++; $display("FAIL mid1_content: got %h want 0", bus.eng_content_o); end
    eng_lat = 8;
    send_words(VEC_P, 0, 4);
    g = 0;
    while (dbg_state != 2'd2 && g < 100) begin
      @(negedge clk_i);
      g++;
    end
    total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL mid2_wait: state %0d want 2", dbg_state); end
    pulse_reset();
    eng_lat = 2;
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL mid2_in_ready: got %b want 1", bus.in_ready_o); end
    total++; if (bus.eng_v_o !== 1'b0) begin bad++; $display("FAIL mid2_eng_v: got %b want 0", bus.eng_v_o); end
    total++; if (bus.eng_yumi_o !== 1'b0) begin bad++; $display("FAIL mid2_yumi: got %b want 0", bus.eng_yumi_o); end
    total++; if (bus.out_data_o !== 32'h0) begin bad++; $display("FAIL mid2_out_data: got %h want 0", bus.out_data_o); end
    total++; if (bus.eng_content_o !== 128'h0) begin bad++; $display("FAIL mid2_content: got %h want 0", bus.eng_content_o); end
    stale = 0;
    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (bus.out_v_o !== 1'b0) stale++;
      @(negedge clk_i);
    end
    bus.out_ready_i = 1'b0;
    total++; if (stale !== 0) begin bad++; $display("FAIL mid2_stale: got %0d valid cycles want 0", stale); end
    push_exp(VEC_C);
    send_words(VEC_P, 0, 4);
    recv_block(1'b0, herr);
    for (int k = 0; k < 4; k++) begin
      w = exp_q.pop_front();
      total++; if (got_q[k] !== w) begin bad++; $display("FAIL after_rst_w%0d: got %h want %h", k, got_q[k], w); end
    end
  endtask

  task automatic test_iv_load();
    int herr;
    logic [31:0] w;
    logic [127:0] exp_blk;
    bus.key_i = VEC_K; bus.decode_i = 1'b0; bus.cbc_en_i = 1'b0;
    pulse_iv(IV1);
    send_words(VEC_P, 0, 1);
    bus.iv_i      = IV2;
    bus.iv_load_i = 1'b1;
    send_words(VEC_P, 1, 3);
    push_exp(VEC_C);
    recv_block(1'b0, herr);
    bus.iv_load_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w = exp_q.pop_front();
      total++; if (got_q[k] !== w) begin bad++; $display("FAIL iv_ecb_w%0d: got %h want %h", k, got_q[k], w); end
    end
    bus.cbc_en_i = 1'b1;
    send_words(VEC_P, 0, 4);
    total++; if (bus.eng_content_o !== (VEC_P ^ IV1)) begin bad++; $display("FAIL iv_content: got %h want %h", bus.eng_content_o, VEC_P ^ IV1); end
    exp_blk = VEC_P ^ IV1 ^ VEC_K ^ VEC_M;
    push_exp(exp_blk);
    recv_block(1'b0, herr);
    for (int k = 0; k < 4; k++) begin
      w = exp_q.pop_front();
      total++; if (got_q[k] !== w) begin bad++; $display("FAIL iv_cbc_w%0d: got %h want %h", k, got_q[k], w); end
    end
    bus.cbc_en_i = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad   = 0;
    eng_lat   = 2;
    eng_stall = 0;
    reset_ni        = 1'b0;
    bus.in_data_i   = '0;
    bus.in_v_i      = 1'b0;
    bus.key_i       = VEC_K;
    bus.decode_i    = 1'b0;
    bus.cbc_en_i    = 1'b0;
    bus.iv_i        = '0;
    bus.iv_load_i   = 1'b0;
    bus.out_ready_i = 1'b0;
    test_reset();
    test_ecb_encrypt();
    test_ecb_decrypt();
    test_cbc();
    test_stall();
    test_reset_mid();
    test_iv_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
